// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the LEGv8 datapath. Owns the program counter,
// requests one 32-bit word at a time from instruction memory over a req/ack
// handshake, and parks the returned word in the instruction register until
// the downstream stage consumes it. At consume time the next PC is chosen
// (sequential or branch redirect). A misaligned redirect target traps the
// unit in a sticky fault state that only reset clears. Consumed instructions
// are counted with a saturating counter.
//
// Parameters
//   RESET_PC       byte address of the first fetch after reset (4-byte aligned)
//
// Ports
//   clk            in   1   single clock, rising edge
//   reset_n        in   1   synchronous active-low reset
//   imem_req       out  1   fetch request to instruction memory
//   imem_addr      out  64  byte address of the requested word (the PC)
//   imem_ack       in   1   imem_rdata valid this cycle (only used in FETCH)
//   imem_rdata     in   32  instruction word from memory
//   instr          out  32  instruction register (decoder / sign-extender)
//   instr_pc       out  64  PC of the word held in instr
//   instr_valid    out  1   instr holds an unconsumed instruction
//   instr_ready    in   1   downstream consumes instr when high with instr_valid
//   branch_taken   in   1   redirect request, sampled only at consume
//   branch_target  in   64  redirect byte address, sampled only at consume
//   fault          out  1   sticky misaligned-branch-target flag
//   fetch_count    out  32  saturating count of consumed instructions
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;
    localparam logic [63:0] PC_STEP   = 64'd4;

    state_e      state_q,       state_d;
    logic [63:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic [63:0] instr_pc_q,    instr_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Handshake/status outputs are registered from the next state so they
    // come straight off flops while still matching the decode of state_q.
    logic        imem_req_q;
    logic        instr_valid_q;
    logic        fault_q;

    logic        consume;
    logic [63:0] seq_pc;
    logic [63:0] redirect_pc;

    // Saturating increment: the counter sticks at all-ones rather than wrap.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == COUNT_MAX) begin
            return v;
        end
        return v + 32'd1;
    endfunction

    // A target is fetchable only if it names a whole 4-byte word.
    function automatic logic is_misaligned(input logic [63:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Consume only happens while a word is parked; ready in any other state
    // (and branch inputs with it) is ignored.
    assign consume     = (state_q == S_HOLD) && instr_ready;

    // Sequential PC wraps modulo 2^64; the wrap itself is not a fault.
    assign seq_pc      = pc_q + PC_STEP;
    assign redirect_pc = branch_taken ? branch_target : seq_pc;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // imem_addr stays on pc_q for every wait cycle until ack.
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (consume) begin
                    fetch_count_d = sat_inc(fetch_count_q);
                    pc_d          = redirect_pc;
                    // The misaligned target is still loaded into pc so the
                    // faulting address is visible on imem_addr afterwards.
                    state_d       = is_misaligned(redirect_pc) ? S_FAULT : S_FETCH;
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_pc_q    <= RESET_PC;
            fetch_count_q <= 32'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
            imem_req_q    <= (state_d == S_FETCH);
            instr_valid_q <= (state_d == S_HOLD);
            fault_q       <= (state_d == S_FAULT);
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    // Architectural reference state: next fetch address, consumed count,
    // and whether a misaligned redirect has trapped the unit.
    logic [63:0] mpc;
    logic [31:0] mcnt;
    logic        mfault;

    logic [63:0] frc_pc;
    logic [31:0] frc_cnt;

    typedef struct {
        int unsigned wc;
        int unsigned st;
        logic [31:0] word;
        logic        tk;
        logic [63:0] tgt;
        logic        fpc_en;
        logic [63:0] fpc;
        logic        fcnt_en;
        logic [31:0] fcnt;
        logic [63:0] exp_addr;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[11];

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        imem_ack     = 1'b0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        tick();
        tick();
        chk("rst_req",   imem_req,    1'b0);
        chk("rst_vld",   instr_valid, 1'b0);
        chk("rst_fault", fault,       1'b0);
        chk("rst_cnt",   fetch_count, 32'd0);
        chk("rst_addr",  imem_addr,   RESET_PC);
        chk("rst_instr", instr,       32'd0);
        chk("rst_ipc",   instr_pc,    RESET_PC);
        mpc     = RESET_PC;
        mcnt    = 32'd0;
        mfault  = 1'b0;
        reset_n = 1'b1;
    endtask

    // One complete fetch/consume transaction with wc memory wait cycles and
    // st back-pressure cycles, optionally preloading pc/count while parked.
    task automatic do_txn(input int unsigned wc, input int unsigned st, input logic [31:0] word,
                          input logic tk, input logic [63:0] tgt,
                          input logic fpc_en, input logic [63:0] fpc,
                          input logic fcnt_en, input logic [31:0] fcnt);
        int n;
        logic [63:0] fetch_pc;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("req_seen", imem_req, 1'b1);
        fetch_pc = mpc;
        chk("fetch_addr", imem_addr, fetch_pc);
        for (int w = 0; w < int'(wc); w++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            tick();
            chk("wait_req",  imem_req,    1'b1);
            chk("wait_addr", imem_addr,   fetch_pc);
            chk("wait_vld",  instr_valid, 1'b0);
        end
        imem_ack      = 1'b1;
        imem_rdata    = word;
        branch_taken  = 1'($urandom_range(0, 1));
        branch_target = {$urandom, $urandom};
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("hold_vld", instr_valid, 1'b1);
        chk("hold_req", imem_req,    1'b0);
        chk("instr",    instr,       {32'd0, word});
        chk("instr_pc", instr_pc,    fetch_pc);
        if (fpc_en) begin
            frc_pc = fpc;
            force dut.pc_q = frc_pc;
            #1;
            release dut.pc_q;
            mpc = fpc;
        end
        if (fcnt_en) begin
            frc_cnt = fcnt;
            force dut.fetch_count_q = frc_cnt;
            #1;
            release dut.fetch_count_q;
            mcnt = fcnt;
        end
        for (int s = 0; s < int'(st); s++) begin
            instr_ready   = 1'b0;
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = {$urandom, $urandom};
            imem_ack      = 1'($urandom_range(0, 1));
            tick();
            chk("bp_vld",   instr_valid, 1'b1);
            chk("bp_req",   imem_req,    1'b0);
            chk("bp_instr", instr,       {32'd0, word});
            chk("bp_ipc",   instr_pc,    fetch_pc);
            chk("bp_addr",  imem_addr,   mpc);
            chk("bp_cnt",   fetch_count, {32'd0, mcnt});
        end
        imem_ack      = 1'b0;
        instr_ready   = 1'b1;
        branch_taken  = tk;
        branch_target = tgt;
        tick();
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = {$urandom, $urandom};
        mpc    = tk ? tgt : mpc + 64'd4;
        mcnt   = (mcnt == 32'hFFFF_FFFF) ? mcnt : mcnt + 32'd1;
        mfault = (mpc % 4) != 0;
        chk("post_addr",  imem_addr,   mpc);
        chk("post_cnt",   fetch_count, {32'd0, mcnt});
        chk("post_fault", fault,       {63'd0, mfault});
        chk("post_vld",   instr_valid, 1'b0);
        chk("post_req",   imem_req,    {63'd0, !mfault});
    endtask

    initial begin
        logic [63:0] t;

        vecs[0]  = '{0, 0, 32'h8B020020, 1'b0, 64'h0,   1'b0, 64'h0, 1'b0, 32'h0, 64'h4,   32'd1};
        vecs[1]  = '{0, 0, 32'h91000421, 1'b0, 64'h0,   1'b0, 64'h0, 1'b0, 32'h0, 64'h8,   32'd2};
        vecs[2]  = '{0, 0, 32'hCB030041, 1'b0, 64'h0,   1'b0, 64'h0, 1'b0, 32'h0, 64'hC,   32'd3};
        vecs[3]  = '{0, 0, 32'hAA0103E2, 1'b0, 64'h0,   1'b0, 64'h0, 1'b0, 32'h0, 64'h10,  32'd4};
        vecs[4]  = '{3, 0, 32'hF84003E1, 1'b0, 64'h0,   1'b0, 64'h0, 1'b0, 32'h0, 64'h14,  32'd5};
        vecs[5]  = '{0, 5, 32'hB4000040, 1'b0, 64'h0,   1'b0, 64'h0, 1'b0, 32'h0, 64'h18,  32'd6};
        vecs[6]  = '{1, 0, 32'h17FFFFFF, 1'b1, 64'h400, 1'b0, 64'h0, 1'b0, 32'h0, 64'h400, 32'd7};
        vecs[7]  = '{0, 0, 32'hD503201F, 1'b0, 64'h0,   1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
                     1'b0, 32'h0, 64'h0, 32'd8};
        vecs[8]  = '{0, 0, 32'h8B1F03E0, 1'b0, 64'h0,   1'b0, 64'h0, 1'b1, 32'hFFFF_FFFE,
                     64'h4, 32'hFFFF_FFFF};
        vecs[9]  = '{0, 1, 32'h8B1F03E1, 1'b0, 64'h0,   1'b0, 64'h0, 1'b0, 32'h0, 64'h8,   32'hFFFF_FFFF};
        vecs[10] = '{2, 0, 32'h8B1F03E2, 1'b0, 64'h0,   1'b0, 64'h0, 1'b0, 32'h0, 64'hC,   32'hFFFF_FFFF};

        reset_n       = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'd0;
        frc_pc        = 64'd0;
        frc_cnt       = 32'd0;

        do_reset();
        tick();
        chk("first_req",  imem_req,  1'b1);
        chk("first_addr", imem_addr, RESET_PC);

        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i].wc, vecs[i].st, vecs[i].word, vecs[i].tk, vecs[i].tgt,
                   vecs[i].fpc_en, vecs[i].fpc, vecs[i].fcnt_en, vecs[i].fcnt);
            chk("vec_addr", imem_addr,   vecs[i].exp_addr);
            chk("vec_cnt",  fetch_count, {32'd0, vecs[i].exp_cnt});
            chk("vec_fault", fault,      1'b0);
        end

        // Randomized aligned traffic against the reference model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            t = {$urandom, $urandom};
            t[1:0] = 2'b00;
            do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   ($urandom_range(0, 3) == 0), t, 1'b0, 64'h0, 1'b0, 32'h0);
        end

        // Branch to aligned 0x400, then misaligned 0x402 traps.
        do_txn(0, 0, 32'h14000100, 1'b1, 64'h400, 1'b0, 64'h0, 1'b0, 32'h0);
        chk("br_addr", imem_addr, 64'h400);
        do_txn(1, 0, 32'h14000101, 1'b1, 64'h402, 1'b0, 64'h0, 1'b0, 32'h0);
        chk("flt_rise", fault, 1'b1);
        for (int i = 0; i < 6; i++) begin
            imem_ack      = 1'($urandom_range(0, 1));
            instr_ready   = 1'($urandom_range(0, 1));
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = 64'h800;
            tick();
            chk("flt_stick", fault,       1'b1);
            chk("flt_req",   imem_req,    1'b0);
            chk("flt_vld",   instr_valid, 1'b0);
            chk("flt_addr",  imem_addr,   64'h402);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;

        // Reset in the middle of a FETCH wait, then a stray ack while IDLE.
        do_reset();
        do_txn(0, 0, 32'hAAAA5555, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 32'h0);
        imem_ack = 1'b0;
        tick();
        chk("mid_wait_req", imem_req, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_req",   imem_req,    1'b0);
        chk("mid_rst_cnt",   fetch_count, 32'd0);
        chk("mid_rst_instr", instr,       32'd0);
        reset_n    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ack = 1'b0;
        mpc    = RESET_PC;
        mcnt   = 32'd0;
        mfault = 1'b0;
        chk("stray_req",   imem_req,    1'b1);
        chk("stray_addr",  imem_addr,   RESET_PC);
        chk("stray_vld",   instr_valid, 1'b0);
        chk("stray_instr", instr,       32'd0);
        chk("stray_ipc",   instr_pc,    RESET_PC);
        chk("stray_cnt",   fetch_count, 32'd0);
        chk("stray_fault", fault,       1'b0);
        tick();
        chk("stray_still_fetch", imem_req, 1'b1);
        chk("stray_still_novld", instr_valid, 1'b0);
        do_txn(2, 1, 32'h12345678, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the LEGv8 datapath. Holds the program counter and issues word requests to instruction memory through a req/ack handshake. Latches the returned 32-bit instruction into an instruction register, which is the sole source of the instruction word seen by the decoder and the immediate sign-extender. Applies branch redirects (PCSrc) when the downstream stage consumes an instruction, traps misaligned targets, and counts consumed instructions.

## Interface
Parameters:
- RESET_PC, 64'h0, byte address of the first fetch after reset; must be 4-byte aligned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  byte address of the requested word; equals the PC.
- imem_ack  in  1  memory has `imem_rdata` valid this cycle; only meaningful while `imem_req`=1.
- imem_rdata  in  32  instruction word returned by memory.
- instr  out  32  instruction register; drives the decoder opcode field and the sign-extender input.
- instr_pc  out  64  PC of the word held in `instr`.
- instr_valid  out  1  `instr` holds an unconsumed instruction.
- instr_ready  in  1  downstream consumes `instr` when high together with `instr_valid`.
- branch_taken  in  1  redirect request (PCSrc); sampled only at consume.
- branch_target  in  64  redirect byte address; sampled only at consume.
- fault  out  1  sticky misaligned-branch-target flag.
- fetch_count  out  32  saturating count of consumed instructions.

## Operation
- Registers: `pc` (64), `instr` (32), `instr_pc` (64), `state`, `fault`, `fetch_count` (32).
- States:
  - IDLE: outputs quiet. Next state is FETCH unconditionally.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
    - On `imem_ack`=1: `instr`<=`imem_rdata`, `instr_pc`<=`pc`, next state HOLD.
    - Otherwise stay in FETCH with `imem_addr` held stable.
  - HOLD: `instr_valid`=1, `imem_req`=0.
    - On `instr_ready`=1 (consume): increment `fetch_count`; next PC is `branch_target` if `branch_taken`=1, else `pc`+4.
    - Next state after consume is FETCH, or FAULT if the chosen target has bits [1:0] != 0.
    - Without `instr_ready`, stay in HOLD; `instr` and `instr_pc` stay stable.
  - FAULT: `fault`=1, `imem_req`=0, `instr_valid`=0. Leave only by reset; `pc` holds the faulting target.
- `imem_req` and `instr_valid` are decoded from `state` and are never high together.
- `imem_addr` = `pc` in all states.
- PC arithmetic is 64-bit modulo 2^64: `pc`+4 from 64'hFFFF_FFFF_FFFF_FFFC wraps to 0, and this is not a fault.
- `branch_taken` and `branch_target` are ignored outside a consume cycle.
- `imem_ack` is ignored outside FETCH, including a late ack that arrives after a reset.
- `fetch_count` saturates at 32'hFFFF_FFFF and does not wrap.

## Timing
- Reset (`reset_n`=0 at an edge), next-cycle values:
  - state IDLE; `pc`=RESET_PC; `instr`=0; `instr_pc`=RESET_PC.
  - `instr_valid`=0, `imem_req`=0, `fault`=0, `fetch_count`=0.
- Reset overrides every other input, in any state, including mid-handshake in FETCH or HOLD.
- First request: `imem_req` rises one cycle after the first edge with `reset_n`=1 (IDLE then FETCH).
- Zero-wait memory (ack in the first FETCH cycle): `instr_valid` rises on the next cycle.
- Each added wait cycle delays `instr_valid` by one cycle.
- Consume with `instr_ready` already high: `instr_valid` drops after one cycle; `imem_req` is high in that following cycle at the new PC.
- Peak throughput: one instruction per 2 cycles.
- A branch target takes effect on `imem_addr` in the cycle after consume; there is no extra bubble.
- `fault` rises in the cycle after the consume that selected the misaligned target; `fetch_count` includes that consume.

## Test plan
- Reset then zero-wait memory, RESET_PC=0, `instr_ready`=1: `imem_addr` sequence 0,4,8,C on alternating cycles; `fetch_count`=4 after the fourth consume; `instr_pc` tracks each address.
- Memory wait of 3 cycles at addr 0x10: `imem_addr` stays 0x10 and `imem_req` stays 1 for all 4 FETCH cycles; `instr`=`imem_rdata` of the ack cycle, e.g. 32'hF84003E1.
- Back-pressure: hold `instr_ready`=0 for 5 cycles in HOLD and toggle `branch_taken` meanwhile: `instr` and `instr_valid` stay stable, `imem_req`=0, and the next fetch address is `pc`+4.
- Branch at consume with target 0x400: the next `imem_addr` is 0x400. Misaligned target 0x402: `fault`=1 next cycle, no further `imem_req`, `pc`=0x402 until reset.
- Reset asserted during a FETCH wait, then a stray `imem_ack` in IDLE: the ack is ignored, the first post-reset request is at RESET_PC, and all outputs hold their reset values.
- Boundaries:
  - `fetch_count` preloaded (via force) to 32'hFFFFFFFE, then 3 consumes: the count ends at 32'hFFFFFFFF.
  - `pc` forced to 64'hFFFF_FFFF_FFFF_FFFC: the next fetch address is 0 with `fault`=0.
